cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file of the 5-stage MIPS core; receiving end of the write-back stage's CP0 bus.
- Commits exceptions, ERET and MTC0 writes at write-back; supplies MFC0 read data combinationally to write-back.
- Runs the Count/Compare timer and produces the interrupt request sampled at decode.
- Exports EPC (ERET target) and the exception flush vector to fetch.

Parameters:
- EX_ENTRY, 32'hBFC00380, exception entry PC driven to fetch on flush.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- wb_to_cp0_bus  input  110  [109] ex, [108:104] excode, [103:72] badvaddr, [71] bd, [70:39] pc, [38] mtc0_we, [37:33] cp0_addr, [32:1] wdata, [0] eret. Fields ex and mtc0_we are already qualified by ws_valid.
- ext_int_in  input  6  hardware interrupt lines, level-sensitive.
- cp0_rdata  output  32  combinational read of register cp0_addr.
- cp0_epc  output  32  current EPC.
- ex_entry  output  32  constant EX_ENTRY.
- has_int  output  1  pending enabled interrupt.

Behaviour:
- Implemented registers (sel 0 only):
  - BadVAddr (8).
  - Count (9).
  - Compare (11).
  - Status (12): Bev[22] hardwired 1; IM[15:8] RW; EXL[1]; IE[0]; all other bits read 0.
  - Cause (13): BD[31]; TI[30]; IP[15:10] hardware; IP[9:8] RW; ExcCode[6:2]; all other bits read 0.
  - EPC (14).
  - Any other address reads 0; writes to it are ignored.
- Reset values:
  - Status = 32'h0040_0000.
  - Cause = 0.
  - Count = 0.
  - Compare = 0.
  - EPC = 0.
  - BadVAddr = 0.
  - Internal tick flop = 0.
  - Outputs follow from these: has_int = 0, cp0_epc = 0.
- Commit priority per cycle: ex > eret > mtc0_we. Only the highest-priority event takes effect.
- Exception commit (ex=1), all updates at the next edge:
  - Status.EXL <= 1.
  - Cause.ExcCode <= excode.
  - If Status.EXL was 0: EPC <= bd ? pc-4 : pc, and Cause.BD <= bd.
  - If Status.EXL was already 1: EPC and BD are unchanged.
  - BadVAddr <= badvaddr only when excode is 5'h04 (AdEL) or 5'h05 (AdES).
- ERET (eret=1, ex=0): Status.EXL <= 0. Nothing else changes.
- MTC0 (mtc0_we=1, ex=0, eret=0): write wdata to the addressed register, masked to its writable bits.
  - Writing Compare also clears Cause.TI.
  - Writing Count overrides the timer increment in that cycle.
  - Writing Cause touches only IP[9:8].
- Timer:
  - tick toggles every cycle.
  - Count increments by 1 when tick==1, wrapping 32'hFFFF_FFFF to 0.
  - Cause.TI <= 1 when Count==Compare, evaluated every cycle, except in a cycle that writes Compare (clear wins).
- Cause.IP[7:2] (bits 15:10) <= {ext_int_in[5] | TI, ext_int_in[4:0]}, registered every cycle.
- has_int = |(Cause[15:8] & Status[15:8]) & Status.IE & ~Status.EXL. Combinational.
- Read path:
  - cp0_rdata reflects register state before the current edge; a same-cycle MTC0 is not bypassed.
  - An MFC0 immediately after an MTC0 to the same register, in the next cycle, sees the new value.
- Reset in any cycle overrides all events: no register update other than reset values.
- No stall or handshake. One commit per cycle; write-back guarantees at most one valid instruction per cycle.

Test Plan:
- Reset, then idle 10 cycles:
  - Status reads 32'h0040_0000.
  - Count reads 5.
  - has_int = 0.
- MTC0 Status = 32'h0000_FF01, then MTC0 Cause = 32'h0000_0100:
  - has_int = 1 the cycle after the Cause write.
  - Then ex=1, excode=0, pc=32'hBFC0_1000, bd=0: EPC = 32'hBFC0_1000, Status.EXL = 1, has_int = 0.
- ex=1, excode=5'h04, bd=1, pc=32'hBFC0_2004, badvaddr=32'h0000_0003 with EXL=0:
  - EPC = 32'hBFC0_2000, Cause.BD = 1, ExcCode = 4, BadVAddr = 32'h3.
  - Second exception (excode=8) while EXL=1: EPC unchanged, ExcCode = 8.
- Then eret=1: EXL clears. ex=1 and eret=1 in the same cycle: EXL = 1 (ex wins).
- MTC0 Compare = 20, Count = 10, Status = 32'h0000_8001:
  - TI and has_int assert once Count reaches 20 (about 20 cycles later).
  - MTC0 Compare = 100 clears TI; has_int drops.
- MTC0 Count = 32'hFFFF_FFFF: Count wraps to 0 within 2 cycles. MTC0 to addr 5'd3 has no effect and reads 0.

Source files
------------

// File: rtl/cp0_regfile.sv
// cp0_regfile -- MIPS coprocessor-0 register file, write-back side.
//
// Commits exceptions, ERET and MTC0 at write-back with the priority
// ex > eret > mtc0. MFC0 data is read combinationally from the registered
// state. Also runs the Count/Compare timer and raises the interrupt request
// that decode samples.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   wb_to_cp0_bus  {ex, excode[4:0], badvaddr[31:0], bd, pc[31:0],
//                   mtc0_we, cp0_addr[4:0], wdata[31:0], eret}
//   ext_int_in     level-sensitive hardware interrupt lines
//   cp0_rdata      combinational read of register cp0_addr
//   cp0_epc        current EPC (ERET target)
//   ex_entry       exception entry PC for the fetch flush
//   has_int        pending, enabled and unmasked interrupt
module cp0_regfile #(
  parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [109:0] wb_to_cp0_bus,
  input  logic [5:0]   ext_int_in,
  output logic [31:0]  cp0_rdata,
  output logic [31:0]  cp0_epc,
  output logic [31:0]  ex_entry,
  output logic         has_int
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  // Bus field decode
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic [31:0] wb_badvaddr;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic        wb_mtc0_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_eret;

  assign wb_ex       = wb_to_cp0_bus[109];
  assign wb_excode   = wb_to_cp0_bus[108:104];
  assign wb_badvaddr = wb_to_cp0_bus[103:72];
  assign wb_bd       = wb_to_cp0_bus[71];
  assign wb_pc       = wb_to_cp0_bus[70:39];
  assign wb_mtc0_we  = wb_to_cp0_bus[38];
  assign wb_addr     = wb_to_cp0_bus[37:33];
  assign wb_wdata    = wb_to_cp0_bus[32:1];
  assign wb_eret     = wb_to_cp0_bus[0];

  // State
  logic        tick_q,       tick_d;
  logic [31:0] count_q,      count_d;
  logic [31:0] compare_q,    compare_d;
  logic [31:0] badvaddr_q,   badvaddr_d;
  logic [31:0] epc_q,        epc_d;
  logic [7:0]  st_im_q,      st_im_d;
  logic        st_exl_q,     st_exl_d;
  logic        st_ie_q,      st_ie_d;
  logic        ca_bd_q,      ca_bd_d;
  logic        ca_ti_q,      ca_ti_d;
  logic [5:0]  ca_ip_hw_q,   ca_ip_hw_d;
  logic [1:0]  ca_ip_sw_q,   ca_ip_sw_d;
  logic [4:0]  ca_exc_q,     ca_exc_d;

  // Only the highest-priority event of the cycle commits
  logic commit_ex;
  logic commit_eret;
  logic commit_mtc0;

  assign commit_ex   = wb_ex;
  assign commit_eret = wb_eret & ~wb_ex;
  assign commit_mtc0 = wb_mtc0_we & ~wb_ex & ~wb_eret;

  logic we_count;
  logic we_compare;
  logic we_status;
  logic we_cause;
  logic we_epc;

  assign we_count   = commit_mtc0 & (wb_addr == ADDR_COUNT);
  assign we_compare = commit_mtc0 & (wb_addr == ADDR_COMPARE);
  assign we_status  = commit_mtc0 & (wb_addr == ADDR_STATUS);
  assign we_cause   = commit_mtc0 & (wb_addr == ADDR_CAUSE);
  assign we_epc     = commit_mtc0 & (wb_addr == ADDR_EPC);

  // Architectural views
  logic [31:0] status_w;
  logic [31:0] cause_w;

  assign status_w = {9'b0, 1'b1, 6'b0, st_im_q, 6'b0, st_exl_q, st_ie_q};
  assign cause_w  = {ca_bd_q, ca_ti_q, 14'b0, ca_ip_hw_q, ca_ip_sw_q,
                     1'b0, ca_exc_q, 2'b0};

  // Next-state logic
  always_comb begin
    tick_d     = ~tick_q;
    count_d    = tick_q ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    st_im_d    = st_im_q;
    st_exl_d   = st_exl_q;
    st_ie_d    = st_ie_q;
    ca_bd_d    = ca_bd_q;
    ca_exc_d   = ca_exc_q;
    ca_ip_sw_d = ca_ip_sw_q;

    // Timer interrupt is sticky; a Compare write clears it and wins over a
    // coincident match.
    if (we_compare) begin
      ca_ti_d = 1'b0;
    end else if (count_q == compare_q) begin
      ca_ti_d = 1'b1;
    end else begin
      ca_ti_d = ca_ti_q;
    end

    // IP7 shares its line with the timer interrupt
    ca_ip_hw_d = {ext_int_in[5] | ca_ti_q, ext_int_in[4:0]};

    if (commit_ex) begin
      st_exl_d = 1'b1;
      ca_exc_d = wb_excode;
      // Nested exceptions keep the original return point
      if (!st_exl_q) begin
        epc_d   = wb_bd ? wb_pc - 32'd4 : wb_pc;
        ca_bd_d = wb_bd;
      end
      if ((wb_excode == EXC_ADEL) || (wb_excode == EXC_ADES)) begin
        badvaddr_d = wb_badvaddr;
      end
    end else if (commit_eret) begin
      st_exl_d = 1'b0;
    end else begin
      if (we_count) begin
        count_d = wb_wdata;
      end
      if (we_compare) begin
        compare_d = wb_wdata;
      end
      if (we_status) begin
        st_im_d  = wb_wdata[15:8];
        st_exl_d = wb_wdata[1];
        st_ie_d  = wb_wdata[0];
      end
      if (we_cause) begin
        ca_ip_sw_d = wb_wdata[9:8];
      end
      if (we_epc) begin
        epc_d = wb_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      badvaddr_q <= '0;
      epc_q      <= '0;
      st_im_q    <= '0;
      st_exl_q   <= 1'b0;
      st_ie_q    <= 1'b0;
      ca_bd_q    <= 1'b0;
      ca_ti_q    <= 1'b0;
      ca_ip_hw_q <= '0;
      ca_ip_sw_q <= '0;
      ca_exc_q   <= '0;
    end else begin
      tick_q     <= tick_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      st_im_q    <= st_im_d;
      st_exl_q   <= st_exl_d;
      st_ie_q    <= st_ie_d;
      ca_bd_q    <= ca_bd_d;
      ca_ti_q    <= ca_ti_d;
      ca_ip_hw_q <= ca_ip_hw_d;
      ca_ip_sw_q <= ca_ip_sw_d;
      ca_exc_q   <= ca_exc_d;
    end
  end

  // MFC0 read path: registered state only, no same-cycle write bypass
  always_comb begin
    cp0_rdata = '0;
    unique case (wb_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr_q;
      ADDR_COUNT:    cp0_rdata = count_q;
      ADDR_COMPARE:  cp0_rdata = compare_q;
      ADDR_STATUS:   cp0_rdata = status_w;
      ADDR_CAUSE:    cp0_rdata = cause_w;
      ADDR_EPC:      cp0_rdata = epc_q;
      default:       cp0_rdata = '0;
    endcase
  end

  assign cp0_epc  = epc_q;
  assign ex_entry = EX_ENTRY;
  assign has_int  = (|(cause_w[15:8] & status_w[15:8])) & st_ie_q & ~st_exl_q;

endmodule
